// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Imported by router_tx_buf and router_pkt_tx.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PLD,
    PAR,
    GAP
  } tx_state_t;

  function automatic logic [DATA_W-1:0] make_header(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len
  );
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_tx_buf.sv
// 64x8 payload buffer for router_pkt_tx.
// Synchronous write, asynchronous read.
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header/payload/parity.
// Optional ROUTER_TX_PAR_CORRUPT_EN adds corrupt_par to invert parity.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IFG_CYCLES = 2,
  parameter int ADDR_MAX   = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              pld_valid,
  input  logic [DATA_W-1:0] pld_data,
  output logic              pld_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_done,
  output logic              req_drop
`ifdef ROUTER_TX_PAR_CORRUPT_EN
  ,
  input  logic              corrupt_par
`endif
);
  localparam logic [7:0] IFG_L = 8'(IFG_CYCLES);
  localparam logic [ADDR_W:0] AMAX = (ADDR_W+1)'(ADDR_MAX);

  tx_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_q, wr_d;
  logic [LEN_W-1:0]  rd_q, rd_d;
  logic [7:0]        gap_q, gap_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic              cor_q, cor_d;
  logic              cor_in;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rd;
  logic              valid_d, done_d, drop_d;
  logic [DATA_W-1:0] data_d;
  logic              xfer;

`ifdef ROUTER_TX_PAR_CORRUPT_EN
  assign cor_in = corrupt_par;
`else
  assign cor_in = 1'b0;
`endif

  assign req_ready = resetn && (state_q == IDLE);
  assign pld_ready = (state_q == LOAD);
  assign xfer      = !busy;

  router_tx_buf u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wr_q),
    .wdata (pld_data),
    .raddr (rd_d),
    .rdata (buf_rd)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    gap_d   = gap_q;
    par_d   = par_q;
    cor_d   = cor_q;
    buf_we  = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (req_len == '0 || {1'b0, req_addr} > AMAX) begin
          drop_d = 1'b1;
        end else begin
          addr_d  = req_addr;
          len_d   = req_len;
          par_d   = make_header(req_addr, req_len);
          cor_d   = cor_in;
          wr_d    = '0;
          state_d = LOAD;
        end
      end
      LOAD: if (pld_valid) begin
        buf_we = 1'b1;
        par_d  = par_q ^ pld_data;
        if (wr_q == len_q - 6'd1) state_d = HDR;
        else wr_d = wr_q + 6'd1;
      end
      HDR: if (xfer) begin
        state_d = PLD;
        rd_d    = '0;
      end
      PLD: if (xfer) begin
        if (rd_q == len_q - 6'd1) state_d = PAR;
        else rd_d = rd_q + 6'd1;
      end
      PAR: if (xfer) begin
        done_d  = 1'b1;
        gap_d   = '0;
        state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q == IFG_L - 8'd1) state_d = IDLE;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state.
  always_comb begin
    valid_d = (state_d == HDR) || (state_d == PLD);
    data_d  = '0;
    unique case (1'b1)
      (state_d == HDR): data_d = make_header(addr_d, len_d);
      (state_d == PLD): data_d = buf_rd;
      (state_d == PAR): data_d = par_d ^ {DATA_W{cor_q}};
      default:          data_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      gap_q     <= '0;
      par_q     <= '0;
      cor_q     <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_done  <= 1'b0;
      req_drop  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      gap_q     <= gap_d;
      par_q     <= par_d;
      cor_q     <= cor_d;
      pkt_valid <= valid_d;
      pkt_data  <= data_d;
      pkt_done  <= done_d;
      req_drop  <= drop_d;
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
// Build with ROUTER_TX_PAR_CORRUPT_EN to also exercise parity corruption.
module tb_router_pkt_tx;
  localparam int IFG = 2;

  logic       clock = 0;
  logic       resetn = 0;
  logic       req_valid = 0;
  logic       req_ready;
  logic [1:0] req_addr = 0;
  logic [5:0] req_len = 0;
  logic       pld_valid = 0;
  logic [7:0] pld_data = 0;
  logic       pld_ready;
  logic       busy = 0;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_done;
  logic       req_drop;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
  logic       corrupt_par = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] pl [64];

  always #5 clock = ~clock;

  router_pkt_tx #(.IFG_CYCLES(IFG), .ADDR_MAX(2)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pld_valid (pld_valid),
    .pld_data  (pld_data),
    .pld_ready (pld_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_done  (pkt_done),
    .req_drop  (req_drop)
`ifdef ROUTER_TX_PAR_CORRUPT_EN
    ,
    .corrupt_par (corrupt_par)
`endif
  );

  // Issue a request and stream pl[0..l-1]; returns on the header cycle.
  task automatic load_pkt(input logic [1:0] a, input logic [5:0] l,
                          input bit toggle);
    req_valid = 1; req_addr = a; req_len = l;
    @(negedge clock);
    req_valid = 0;
    for (int i = 0; i < int'(l); i++) begin
      if (toggle && $urandom_range(0, 1) == 1) begin
        pld_valid = 0;
        @(negedge clock);
      end
      pld_valid = 1; pld_data = pl[i];
      @(negedge clock);
    end
    pld_valid = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({pkt_valid, pkt_data, pkt_done, req_drop, pld_ready, req_ready}
        !== 13'h0) begin
      bad++;
      $display("FAIL reset_outs: got v=%b d=%h dn=%b dr=%b pr=%b rr=%b want 0",
               pkt_valid, pkt_data, pkt_done, req_drop, pld_ready, req_ready);
    end
    resetn = 1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rr=%b v=%b want rr=1 v=0",
               req_ready, pkt_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] ed [8] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 0, 0, 0};
    logic       ev [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic       en [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic       er [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    load_pkt(2'd1, 6'd3, 0);
    total++;
    if (pld_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_pld_ready: got %b want 0", pld_ready);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clock);
      total++;
      if (pkt_valid !== ev[k] || pkt_data !== ed[k] || pkt_done !== en[k] ||
          req_ready !== er[k]) begin
        bad++;
        $display("FAIL basic[%0d]: got v=%b d=%h dn=%b rr=%b want v=%b d=%h dn=%b rr=%b",
                 k, pkt_valid, pkt_data, pkt_done, req_ready,
                 ev[k], ed[k], en[k], er[k]);
      end
    end
  endtask

  task automatic test_busy();
    logic [7:0] ed [9] = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                           8'h33, 8'h0D, 0};
    logic       ev [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       en [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    load_pkt(2'd1, 6'd3, 0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clock);
      total++;
      if (pkt_valid !== ev[k] || pkt_data !== ed[k] || pkt_done !== en[k]) begin
        bad++;
        $display("FAIL busy[%0d]: got v=%b d=%h dn=%b want v=%b d=%h dn=%b",
                 k, pkt_valid, pkt_data, pkt_done, ev[k], ed[k], en[k]);
      end
      busy = (k >= 2 && k <= 4);
    end
    @(negedge clock);
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_idle: got rr=%b want 1", req_ready);
    end
  endtask

  task automatic test_drop();
    logic [1:0] aa [2] = '{2'd3, 2'd1};
    logic [5:0] ll [2] = '{6'd5, 6'd0};
    for (int k = 0; k < 2; k++) begin
      req_valid = 1; req_addr = aa[k]; req_len = ll[k];
      @(negedge clock);
      req_valid = 0;
      total++;
      if (req_drop !== 1'b1 || pld_ready !== 1'b0 || pkt_valid !== 1'b0 ||
          req_ready !== 1'b1) begin
        bad++;
        $display("FAIL drop[%0d]: got dr=%b pr=%b v=%b rr=%b want 1 0 0 1",
                 k, req_drop, pld_ready, pkt_valid, req_ready);
      end
      @(negedge clock);
      total++;
      if (req_drop !== 1'b0 || pld_ready !== 1'b0 || pkt_valid !== 1'b0) begin
        bad++;
        $display("FAIL drop_after[%0d]: got dr=%b pr=%b v=%b want 0 0 0",
                 k, req_drop, pld_ready, pkt_valid);
      end
    end
  endtask

  task automatic test_long();
    logic [7:0] p;
    p = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pl[i] = 8'($urandom);
      p = p ^ pl[i];
    end
    load_pkt(2'd2, 6'd63, 1);
    total++;
    if (pkt_valid !== 1'b1 || pkt_data !== 8'hFE) begin
      bad++;
      $display("FAIL long_hdr: got v=%b d=%h want v=1 d=fe", pkt_valid, pkt_data);
    end
    for (int i = 0; i < 63; i++) begin
      @(negedge clock);
      total++;
      if (pkt_valid !== 1'b1 || pkt_data !== pl[i]) begin
        bad++;
        $display("FAIL long_byte[%0d]: got v=%b d=%h want v=1 d=%h",
                 i, pkt_valid, pkt_data, pl[i]);
      end
    end
    @(negedge clock);
    total++;
    if (pkt_valid !== 1'b0 || pkt_data !== p) begin
      bad++;
      $display("FAIL long_par: got v=%b d=%h want v=0 d=%h", pkt_valid, pkt_data, p);
    end
    @(negedge clock);
    total++;
    if (pkt_done !== 1'b1) begin
      bad++;
      $display("FAIL long_done: got %b want 1", pkt_done);
    end
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    load_pkt(2'd1, 6'd3, 0);
    @(negedge clock);
    total++;
    if (pkt_data !== 8'h11) begin
      bad++;
      $display("FAIL rst_pre: got d=%h want 11", pkt_data);
    end
    resetn = 0;
    @(negedge clock);
    resetn = 1;
    total++;
    if (pkt_valid !== 1'b0 || pkt_data !== 8'h00 || pld_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got v=%b d=%h pr=%b want 0 00 0",
               pkt_valid, pkt_data, pld_ready);
    end
    @(negedge clock);
    total++;
    if (pkt_valid !== 1'b0 || pkt_data !== 8'h00 || req_ready !== 1'b1 ||
        pkt_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: got v=%b d=%h rr=%b dn=%b want 0 00 1 0",
               pkt_valid, pkt_data, req_ready, pkt_done);
    end
  endtask

  task automatic test_back_to_back();
    int hdrs, low, c_done, c_ld, idx, parn;
    logic prev_v;
    logic [7:0] par1, exp_par;
    logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
`ifdef ROUTER_TX_PAR_CORRUPT_EN
    exp_par = 8'hF2;
    corrupt_par = 1;
`else
    exp_par = 8'h0D;
`endif
    hdrs = 0; low = 0; c_done = -1; c_ld = -1; idx = 0; parn = 0;
    prev_v = 0; par1 = 0;
    req_valid = 1; req_addr = 2'd1; req_len = 6'd3;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock);
      if (pkt_valid && !prev_v) hdrs++;
      if (!pkt_valid && prev_v && parn == 0) begin
        par1 = pkt_data;
        parn = 1;
      end
      if (hdrs == 1 && parn == 1 && !pkt_valid) low++;
      if (pkt_done && c_done < 0) c_done = cyc;
      if (pld_ready && c_done >= 0 && c_ld < 0) c_ld = cyc;
      if (pld_ready) begin
        pld_valid = 1;
        pld_data = seq[idx % 3];
        idx++;
      end else begin
        pld_valid = 0;
      end
      if (idx >= 4) req_valid = 0;
      prev_v = pkt_valid;
    end
    pld_valid = 0;
`ifdef ROUTER_TX_PAR_CORRUPT_EN
    corrupt_par = 0;
`endif
    total++;
    if (par1 !== exp_par) begin
      bad++;
      $display("FAIL b2b_parity: got %h want %h", par1, exp_par);
    end
    total++;
    if (hdrs != 2) begin
      bad++;
      $display("FAIL b2b_headers: got %0d want 2", hdrs);
    end
    total++;
    if (low < IFG + 1) begin
      bad++;
      $display("FAIL b2b_gap: got %0d low cycles want >= %0d", low, IFG + 1);
    end
    total++;
    if (c_ld - c_done != IFG + 1) begin
      bad++;
      $display("FAIL b2b_accept: got %0d cycles want %0d", c_ld - c_done, IFG + 1);
    end
    total++;
    if (req_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got rr=%b v=%b want 1 0", req_ready, pkt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_drop();
    test_long();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
